// File: rtl/mavg_pkg.sv
// Shared types and constants for the round-robin 3-tap moving-sum scheduler.
package mavg_pkg;

    localparam int DW_DEF = 8;
    localparam int OW_DEF = DW_DEF + 2;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int SAT_MAX_DEF = (1 << (DW_DEF - 1)) - 1;
    localparam int SAT_MIN_DEF = -(1 << (DW_DEF - 1));

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first eligible channel after ptr, one-hot grant.
module rr_arbiter
    import mavg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = ch_w(NCH)
) (
    input  logic [NCH-1:0] eligible,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] grant
);

    logic          found;
    logic [CW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Walk ptr+1 .. ptr+NCH so the last winner has lowest priority.
        for (int k = 1; k <= NCH; k++) begin
            idx = CW'((int'(ptr) + k) % NCH);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mavg_rr_sched.sv
// Shares one 3-tap moving-sum datapath among NCH channels via round-robin grant.
// Optional: define MAVG_SAT_EN to clamp results to the signed DW range.
module mavg_rr_sched
    import mavg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = DW_DEF,
    parameter int OW  = DW + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*DW-1:0]       din,
    input  logic [NCH-1:0]          clr,
    output logic [NCH-1:0]          ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OW-1:0]           out_data,
    output logic [$clog2(NCH)-1:0]  out_ch
);

    localparam int CW = $clog2(NCH);

    state_t                state, state_nxt;
    logic [CW-1:0]         ptr, g;
    logic [NCH-1:0]        eligible, grant;
    logic                  slot_free, take;
    logic signed [DW-1:0]  h1 [NCH];
    logic signed [DW-1:0]  h2 [NCH];
    logic signed [DW-1:0]  s_din, s_h1, s_h2;
    logic signed [OW-1:0]  sum, res;

    // A cleared channel is never eligible in the same cycle.
    assign eligible  = req & ~clr;
    assign slot_free = (state == IDLE) || out_ready;
    assign ack       = slot_free ? grant : '0;
    assign take      = |ack;
    assign out_valid = (state == VALID);

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    always_comb begin
        g     = '0;
        s_din = '0;
        s_h1  = '0;
        s_h2  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant[c]) begin
                g     = CW'(c);
                s_din = din[c*DW +: DW];
                s_h1  = h1[c];
                s_h2  = h2[c];
            end
        end
    end

    assign sum = OW'(s_din) + OW'(s_h1) + OW'(s_h2);

`ifdef MAVG_SAT_EN
    localparam logic signed [OW-1:0] SAT_HI = OW'(sat_max(DW));
    localparam logic signed [OW-1:0] SAT_LO = OW'(sat_min(DW));

    always_comb begin
        res = sum;
        if (sum > SAT_HI)
            res = SAT_HI;
        else if (sum < SAT_LO)
            res = SAT_LO;
    end
`else
    assign res = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A grant while VALID reloads the slot directly, so draining costs no bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = VALID;
            VALID: begin
                if (take)
                    state_nxt = VALID;
                else if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= CW'(NCH - 1);
        end else if (take) begin
            out_data <= res;
            out_ch   <= g;
            ptr      <= g;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                h1[c] <= '0;
                h2[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (clr[c]) begin
                    h1[c] <= '0;
                    h2[c] <= '0;
                end else if (ack[c]) begin
                    h2[c] <= h1[c];
                    h1[c] <= din[c*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_mavg_rr_sched.sv
// Directed bench for mavg_rr_sched with a per-cycle behavioural model and literal result list.
module tb_mavg_rr_sched;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int OW  = DW + 2;

`ifdef MAVG_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  req = '0;
    logic [NCH-1:0]  clr = '0;
    logic [NCH*DW-1:0] din = '0;
    logic [NCH-1:0]  ack;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic [1:0]      out_ch;

    always #5 clk = ~clk;

    mavg_rr_sched #(
        .NCH (NCH),
        .DW  (DW),
        .OW  (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .clr       (clr),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    typedef struct {
        int ch;
        int data;
    } res_t;

    res_t lit_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 1'b0;

    function automatic int pick(input int full, input int satv);
        return SAT ? satv : full;
    endfunction

    function automatic int clip(input int v);
        if (!SAT) return v;
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int d);
        res_t r;
        r.ch   = ch;
        r.data = d;
        lit_q.push_back(r);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] cl, input logic rdy,
                        input int d0, input int d1, input int d2, input int d3);
        req       = r;
        clr       = cl;
        out_ready = rdy;
        din       = {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
        @(posedge clk);
        #1;
    endtask

    // Model: one result slot, per-channel history, last-granted channel.
    initial begin : cmp
        int   m_h1 [NCH];
        int   m_h2 [NCH];
        int   m_last, m_data, m_ch, g, c, d;
        bit   m_valid;
        res_t r;
        m_last = NCH - 1; m_valid = 0; m_data = 0; m_ch = 0;
        for (int i = 0; i < NCH; i++) begin m_h1[i] = 0; m_h2[i] = 0; end
        while (!stim_done) begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_data", int'($signed(out_data)), 0);
                chk("rst_ch", int'(out_ch), 0);
                m_last = NCH - 1; m_valid = 0; m_data = 0; m_ch = 0;
                for (int i = 0; i < NCH; i++) begin m_h1[i] = 0; m_h2[i] = 0; end
                continue;
            end
            chk("valid", int'(out_valid), int'(m_valid));
            if (m_valid) begin
                chk("data", int'($signed(out_data)), m_data);
                chk("ch", int'(out_ch), m_ch);
            end
            if (m_valid && out_ready) begin
                if (lit_q.size() > 0) begin
                    r = lit_q.pop_front();
                    chk("lit_ch", int'(out_ch), r.ch);
                    chk("lit_data", int'($signed(out_data)), r.data);
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL lit_extra: got unlisted result %0d, expected none", $signed(out_data));
                end
            end
            g = -1;
            if (!m_valid || out_ready) begin
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last + k) % NCH;
                    if (g < 0 && req[c] && !clr[c]) g = c;
                end
            end
            chk("ack", int'(ack), (g < 0) ? 0 : (1 << g));
            for (int i = 0; i < NCH; i++)
                if (clr[i]) begin m_h1[i] = 0; m_h2[i] = 0; end
            if (g >= 0) begin
                d       = int'($signed(din[g*DW +: DW]));
                m_data  = clip(d + m_h1[g] + m_h2[g]);
                m_ch    = g;
                m_h2[g] = m_h1[g];
                m_h1[g] = d;
                m_last  = g;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        chk("lit_left", lit_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : stim
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // All channels requesting, constant samples: strict 0,1,2,3 rotation.
        for (int rd = 1; rd <= 3; rd++)
            for (int c = 0; c < NCH; c++) push(c, rd * (c + 1));
        push(0, 10); push(0, 30); push(0, 60);
        repeat (12) step(4'b1111, 4'b0000, 1'b1, 1, 2, 3, 4);

        // Single requester streams back to back.
        step(4'b0000, 4'b0001, 1'b1, 0, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 10, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 20, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 30, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 40, 0, 0, 0);

        // Backpressure holds the slot; release grants ch1 in the same cycle.
        push(0, 90); push(1, 9); push(1, 12);
        step(4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0);
        step(4'b0010, 4'b0000, 1'b1, 0, 5, 0, 0);
        repeat (3) step(4'b0010, 4'b0000, 1'b0, 0, 5, 0, 0);
        step(4'b0010, 4'b0000, 1'b1, 0, 5, 0, 0);
        step(4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0);

        // Signed extremes and saturation on ch2.
        push(2, -128); push(2, pick(-256, -128)); push(2, pick(-384, -128));
        push(2, 127);  push(2, pick(254, 127));   push(2, pick(381, 127));
        push(2, 100);  push(2, pick(200, 127));   push(2, pick(300, 127));
        step(4'b0000, 4'b0100, 1'b1, 0, 0, 0, 0);
        repeat (3) step(4'b0100, 4'b0000, 1'b1, 0, 0, -128, 0);
        step(4'b0000, 4'b0100, 1'b1, 0, 0, 0, 0);
        repeat (3) step(4'b0100, 4'b0000, 1'b1, 0, 0, 127, 0);
        step(4'b0000, 4'b0100, 1'b1, 0, 0, 0, 0);
        repeat (3) step(4'b0100, 4'b0000, 1'b1, 0, 0, 100, 0);
        step(4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0);

        // clr beats req and wipes ch0 history.
        push(0, 10); push(0, 30); push(0, 5);
        step(4'b0000, 4'b0001, 1'b1, 0, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 10, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 20, 0, 0, 0);
        step(4'b0001, 4'b0001, 1'b1, 99, 0, 0, 0);
        step(4'b0001, 4'b0000, 1'b1, 5, 0, 0, 0);
        step(4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0);

        // Async reset drops a pending result; priority restarts at ch0.
        push(0, 7); push(1, 1);
        step(4'b0001, 4'b0000, 1'b0, 9, 0, 0, 0);
        rst = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 0, 0, 0, 0);
        step(4'b0000, 4'b0000, 1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        step(4'b1111, 4'b0000, 1'b1, 7, 1, 0, 0);
        step(4'b1111, 4'b0000, 1'b1, 7, 1, 0, 0);
        req = 4'b0000;
        step(4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0);
        step(4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timeout");
    end

endmodule
